// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start bit (0), 1..16 data bits LSB first, optional parity bit, one stop bit (1).
// The serial line passes through a two-flop synchronizer. Each bit is taken at mid-bit,
// and the assembled word is presented with a one-cycle valid pulse plus parity and framing status.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit becomes the 2-of-3 majority of the
// synchronized line at mid-bit ticks OVERSAMPLE/2-2, -1 and +0. The decision is taken one tick later.
// OVERSAMPLE must be even and at least 4.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  parity,
    input  logic [3:0]  width,
    input  logic        in,
    output logic [15:0] bits,
    output logic        valid,
    output logic        parity_error,
    output logic        frame_error
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    // 2-of-3 majority used by the vote filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic          sync1_q, sync1_d;
    logic          sin_q, sin_d;
    logic          sin_prev_q, sin_prev_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    idx_q, idx_d;
    logic [4:0]    nbits_q, nbits_d;
    logic [1:0]    par_cfg_q, par_cfg_d;
    logic [15:0]   shift_q, shift_d;
    logic          xor_q, xor_d;
    logic          perr_q, perr_d;
    logic          valid_q, valid_d;
    logic [15:0]   bits_q, bits_d;
    logic          parity_error_q, parity_error_d;
    logic          frame_error_q, frame_error_d;

    logic          fall_s;
    logic          samp_tick_s;
    logic          samp_val_s;
    logic [CW-1:0] cnt_inc_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // hist_q[0] holds sin one tick ago, hist_q[1] two ticks ago
    logic [1:0]    hist_q, hist_d;

    assign samp_val_s = maj3(hist_q[1], hist_q[0], sin_q);
`else
    assign samp_val_s = sin_q;
`endif

    assign fall_s      = sin_prev_q & ~sin_q;
    assign samp_tick_s = (cnt_q == CNT_SAMPLE);
    assign cnt_inc_s   = (cnt_q == CNT_LAST) ? {CW{1'b0}} : (cnt_q + CW'(1));

    // Next-state and datapath logic of the receive state machine
    always_comb begin
        sync1_d        = in;
        sin_d          = sync1_q;
        sin_prev_d     = sin_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        nbits_d        = nbits_q;
        par_cfg_d      = par_cfg_q;
        shift_d        = shift_q;
        xor_d          = xor_q;
        perr_d         = perr_q;
        valid_d        = 1'b0;
        bits_d         = bits_q;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
        hist_d         = {hist_q[0], sin_q};
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = {CW{1'b0}};
                if (fall_s) begin
                    // Frame configuration is frozen here; later input changes are ignored
                    par_cfg_d = parity;
                    nbits_d   = (width == 4'd0) ? 5'd16 : {1'b0, width};
                    idx_d     = 5'd0;
                    shift_d   = 16'd0;
                    xor_d     = 1'b0;
                    perr_d    = 1'b0;
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // The count keeps running, so it reaches the sample point again at mid-bit
                cnt_d = cnt_inc_s;
                if (samp_tick_s) begin
                    if (samp_val_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                cnt_d = cnt_inc_s;
                if (samp_tick_s) begin
                    shift_d[idx_q[3:0]] = samp_val_s;
                    xor_d               = xor_q ^ samp_val_s;
                    idx_d               = idx_q + 5'd1;
                    if ((idx_q + 5'd1) == nbits_q) begin
                        if (par_cfg_q[1]) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_STOP;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                cnt_d = cnt_inc_s;
                if (samp_tick_s) begin
                    perr_d  = samp_val_s ^ xor_q ^ par_cfg_q[0];
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                cnt_d = cnt_inc_s;
                if (samp_tick_s) begin
                    valid_d        = 1'b1;
                    bits_d         = shift_q;
                    parity_error_d = par_cfg_q[1] & perr_q;
                    frame_error_d  = ~samp_val_s;
                    // A good stop bit returns to IDLE at once, so back-to-back frames are received
                    if (samp_val_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_HIGH;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = {CW{1'b0}};
                if (sin_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_HIGH;
                end
            end
            default: begin
                cnt_d   = {CW{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State, synchronizer and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q        <= 1'b1;
            sin_q          <= 1'b1;
            sin_prev_q     <= 1'b1;
            state_q        <= S_IDLE;
            cnt_q          <= {CW{1'b0}};
            idx_q          <= 5'd0;
            nbits_q        <= 5'd0;
            par_cfg_q      <= 2'b00;
            shift_q        <= 16'd0;
            xor_q          <= 1'b0;
            perr_q         <= 1'b0;
            valid_q        <= 1'b0;
            bits_q         <= 16'd0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q         <= 2'b11;
`endif
        end else begin
            sync1_q        <= sync1_d;
            sin_q          <= sin_d;
            sin_prev_q     <= sin_prev_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            nbits_q        <= nbits_d;
            par_cfg_q      <= par_cfg_d;
            shift_q        <= shift_d;
            xor_q          <= xor_d;
            perr_q         <= perr_d;
            valid_q        <= valid_d;
            bits_q         <= bits_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
            hist_q         <= hist_d;
`endif
        end
    end

    assign bits         = bits_q;
    assign valid        = valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives line waveforms built tick by tick.
// The expected outputs for every cycle come from a frame decoder that works on the synchronized line
// using bit-time arithmetic, with literal expectations for the directed frames.
module tb_uart_rx;

    localparam int OS   = 16;
    localparam int H    = OS / 2;
    localparam int MAXN = 2048;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  parity = 2'b00;
    logic [3:0]  width = 4'd0;
    logic        in = 1'b1;
    logic [15:0] bits;
    logic        valid, parity_error, frame_error;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clock(clock), .reset(reset), .parity(parity), .width(width), .in(in),
        .bits(bits), .valid(valid), .parity_error(parity_error), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int vec_cnt = 0;
    int miss_cnt = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // Stimulus per tick: line value, width and parity applied just after posedge t
    logic        L_a [MAXN];
    logic [3:0]  W_a [MAXN];
    logic [1:0]  P_a [MAXN];
    int          n_ticks;

    // Expected outputs per cycle
    logic        e_valid [MAXN];
    logic [15:0] e_bits  [MAXN];
    logic        e_pe    [MAXN];
    logic        e_fe    [MAXN];

    int          mq_cyc[$];
    logic [15:0] mq_bits[$];
    logic        mq_pe[$], mq_fe[$];
    int          dq_cyc[$];
    logic [15:0] dq_bits[$];
    logic        dq_pe[$], dq_fe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Synchronized line seen by the receiver during cycle c (two-flop delay, idle high before)
    function automatic logic sv(input int c);
        if (c < 2 || (c - 2) >= n_ticks) return 1'b1;
        return L_a[c - 2];
    endfunction

    function automatic logic bitval(input int m);
`ifdef UART_RX_MAJORITY_VOTE_EN
        int s;
        s = int'(sv(m - 1)) + int'(sv(m)) + int'(sv(m + 1));
        return (s >= 2);
`else
        return sv(m);
`endif
    endfunction

    // Decode the whole waveform into frames, then spread them into per-cycle expectations
    task automatic run_model();
        int c, m, nw, w, v;
        logic [1:0]  pc;
        logic [15:0] acc;
        logic x, pe, stopb, ok;
        logic [15:0] cb;
        logic cpe, cfe;
        mq_cyc.delete(); mq_bits.delete(); mq_pe.delete(); mq_fe.delete();
        for (int i = 0; i < MAXN; i++) e_valid[i] = 1'b0;
        c = 0;
        while (c < n_ticks) begin
            if (sv(c) == 1'b0 && sv(c - 1) == 1'b1) begin
                nw = (W_a[c] == 4'd0) ? 16 : int'(W_a[c]);
                pc = P_a[c];
                m  = c + H;
                if (m + D >= n_ticks) break;
                if (bitval(m)) begin
                    c = m + D + 1;
                    continue;
                end
                acc = 16'd0; x = 1'b0; ok = 1'b1;
                for (int j = 0; j < nw; j++) begin
                    acc[j] = bitval(c + H + OS * (j + 1));
                    x = x ^ acc[j];
                end
                pe = 1'b0;
                if (pc[1]) pe = bitval(c + H + OS * (nw + 1)) ^ x ^ pc[0];
                m = c + H + OS * (nw + 1 + int'(pc[1]));
                if (m + D + 1 >= n_ticks) break;
                stopb = bitval(m);
                v = m + D + 1;
                e_valid[v] = 1'b1; e_bits[v] = acc; e_pe[v] = pe; e_fe[v] = ~stopb;
                mq_cyc.push_back(v); mq_bits.push_back(acc); mq_pe.push_back(pe); mq_fe.push_back(~stopb);
                if (stopb) begin
                    c = v;
                end else begin
                    w = v;
                    while (w < n_ticks && sv(w) == 1'b0) w++;
                    c = w + 1;
                end
            end else begin
                c++;
            end
        end
        cb = 16'd0; cpe = 1'b0; cfe = 1'b0;
        for (int i = 0; i < n_ticks; i++) begin
            if (e_valid[i]) begin
                cb = e_bits[i]; cpe = e_pe[i]; cfe = e_fe[i];
            end
            e_bits[i] = cb; e_pe[i] = cpe; e_fe[i] = cfe;
        end
    endtask

    task automatic add_level(input logic v, input int k, input logic [3:0] w, input logic [1:0] p);
        for (int i = 0; i < k; i++) begin
            if (n_ticks < MAXN) begin
                L_a[n_ticks] = v; W_a[n_ticks] = w; P_a[n_ticks] = p;
                n_ticks++;
            end
        end
    endtask

    task automatic add_frame(input logic [15:0] d, input logic [3:0] w, input logic [1:0] p,
                             input logic pbit, input logic stopb);
        int nb;
        nb = (w == 4'd0) ? 16 : int'(w);
        add_level(1'b0, OS, w, p);
        for (int j = 0; j < nb; j++) add_level(d[j], OS, w, p);
        if (p[1]) add_level(pbit, OS, w, p);
        add_level(stopb, OS, w, p);
    endtask

    // Reset, then drive the built waveform one tick per clock while the compare process checks
    task automatic run_segment();
        run_model();
        dq_cyc.delete(); dq_bits.delete(); dq_pe.delete(); dq_fe.delete();
        @(negedge clock);
        reset = 1'b0; in = 1'b1; width = 4'd0; parity = 2'b00;
        #1;
        check("reset bits", bits, 16'h0000);
        check("reset flags", {valid, parity_error, frame_error}, 3'b000);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int t = 0; t < n_ticks; t++) begin
            @(posedge clock);
            #1;
            in = L_a[t]; width = W_a[t]; parity = P_a[t];
            cyc = t; chk_en = 1'b1;
        end
        @(posedge clock);
        #1 chk_en = 1'b0;
    endtask

    // Literal expectation for the idx-th frame of a segment, against model and DUT
    task automatic pin(input string name, input int idx, input int ecyc, input logic [15:0] eb,
                       input logic epe, input logic efe);
        if (mq_bits.size() > idx) begin
            if (ecyc >= 0) check({name, " model cycle"}, mq_cyc[idx], ecyc);
            check({name, " model bits"}, mq_bits[idx], eb);
            check({name, " model pe/fe"}, {mq_pe[idx], mq_fe[idx]}, {epe, efe});
        end else begin
            check({name, " model has frame"}, 32'd0, 32'd1);
        end
        if (dq_bits.size() > idx) begin
            if (ecyc >= 0) check({name, " dut cycle"}, dq_cyc[idx], ecyc);
            check({name, " dut bits"}, dq_bits[idx], eb);
            check({name, " dut pe/fe"}, {dq_pe[idx], dq_fe[idx]}, {epe, efe});
        end else begin
            check({name, " dut has frame"}, 32'd0, 32'd1);
        end
    endtask

    task automatic pin_count(input string name, input int n);
        check({name, " model count"}, mq_bits.size(), n);
        check({name, " dut count"}, dq_bits.size(), n);
    endtask

    // Compare process: every driven cycle, all outputs against the model
    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                vec_cnt++;
                if (valid !== e_valid[cyc] || bits !== e_bits[cyc] ||
                    parity_error !== e_pe[cyc] || frame_error !== e_fe[cyc]) begin
                    miss_cnt++;
                    $display("FAIL cycle %0d valid/bits/pe/fe: got %b/%h/%b/%b, expected %b/%h/%b/%b",
                             cyc, valid, bits, parity_error, frame_error,
                             e_valid[cyc], e_bits[cyc], e_pe[cyc], e_fe[cyc]);
                end
                if (valid === 1'b1) begin
                    dq_cyc.push_back(cyc); dq_bits.push_back(bits);
                    dq_pe.push_back(parity_error); dq_fe.push_back(frame_error);
                end
            end
        end
    end

    initial begin
        logic [15:0] d, mask;
        logic [3:0]  w, nw;
        logic [1:0]  p, np;
        logic        pb, sb;
        int          nb, nf, fs, cut, g;

        // 0xA5, 8 bits, no parity; stop mid-bit lands at cycle 174, valid one cycle later
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b00);
        add_frame(16'h00A5, 4'd8, 2'b00, 1'b0, 1'b1);
        add_level(1'b1, 30, 4'd8, 2'b00);
        run_segment();
        pin_count("a5", 1);
        pin("a5", 0, 175 + D, 16'h00A5, 1'b0, 1'b0);

        // Odd parity: 0xA5 has four ones, so the correct parity bit is 1
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b11);
        add_frame(16'h00A5, 4'd8, 2'b11, 1'b1, 1'b1);
        add_level(1'b1, 10, 4'd8, 2'b11);
        add_frame(16'h00A5, 4'd8, 2'b11, 1'b0, 1'b1);
        add_level(1'b1, 30, 4'd8, 2'b11);
        run_segment();
        pin_count("odd", 2);
        pin("odd ok", 0, -1, 16'h00A5, 1'b0, 1'b0);
        pin("odd bad", 1, -1, 16'h00A5, 1'b1, 1'b0);

        // 16-bit even parity, back to back; 0xBEEF has 13 ones and 0x0001 has one, so both carry parity bit 1
        n_ticks = 0;
        add_level(1'b1, 20, 4'd0, 2'b10);
        add_frame(16'hBEEF, 4'd0, 2'b10, 1'b1, 1'b1);
        add_frame(16'h0001, 4'd0, 2'b10, 1'b1, 1'b1);
        add_level(1'b1, 30, 4'd0, 2'b10);
        run_segment();
        pin_count("b2b", 2);
        pin("b2b 1", 0, -1, 16'hBEEF, 1'b0, 1'b0);
        pin("b2b 2", 1, -1, 16'h0001, 1'b0, 1'b0);

        // 3-tick low glitch on an idle line, then 0x3C
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b00);
        add_level(1'b0, 3, 4'd8, 2'b00);
        add_level(1'b1, 30, 4'd8, 2'b00);
        add_frame(16'h003C, 4'd8, 2'b00, 1'b0, 1'b1);
        add_level(1'b1, 30, 4'd8, 2'b00);
        run_segment();
        pin_count("glitch", 1);
        pin("glitch", 0, -1, 16'h003C, 1'b0, 1'b0);

        // One-tick high spike exactly at mid of data bit 2 of 0x00
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b00);
        fs = n_ticks;
        add_frame(16'h0000, 4'd8, 2'b00, 1'b0, 1'b1);
        L_a[fs + 3 * OS + H] = 1'b1;
        add_level(1'b1, 30, 4'd8, 2'b00);
        run_segment();
        pin_count("spike", 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
        pin("spike", 0, -1, 16'h0000, 1'b0, 1'b0);
`else
        pin("spike", 0, -1, 16'h0004, 1'b0, 1'b0);
`endif

        // 5-bit 10110 with a low stop bit, line held low, then a good frame 0x0A
        n_ticks = 0;
        add_level(1'b1, 20, 4'd5, 2'b00);
        add_frame(16'h0016, 4'd5, 2'b00, 1'b0, 1'b0);
        add_level(1'b0, 40, 4'd5, 2'b00);
        add_level(1'b1, 30, 4'd5, 2'b00);
        add_frame(16'h000A, 4'd5, 2'b00, 1'b0, 1'b1);
        add_level(1'b1, 30, 4'd5, 2'b00);
        run_segment();
        pin_count("break", 2);
        pin("break", 0, -1, 16'h0016, 1'b0, 1'b1);
        pin("after break", 1, -1, 16'h000A, 1'b0, 1'b0);

        // Good frame, then a frame cut off in the middle of data bit 4 by reset
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b00);
        add_frame(16'h0033, 4'd8, 2'b00, 1'b0, 1'b1);
        add_level(1'b1, 10, 4'd8, 2'b00);
        fs = n_ticks;
        add_frame(16'h00C3, 4'd8, 2'b00, 1'b0, 1'b1);
        n_ticks = fs + 5 * OS + H;
        run_segment();
        pin_count("pre-abort", 1);
        pin("pre-abort", 0, -1, 16'h0033, 1'b0, 1'b0);
        n_ticks = 0;
        add_level(1'b1, 20, 4'd8, 2'b00);
        add_frame(16'h005A, 4'd8, 2'b00, 1'b0, 1'b1);
        add_level(1'b1, 30, 4'd8, 2'b00);
        run_segment();
        pin_count("post-abort", 1);
        pin("post-abort", 0, -1, 16'h005A, 1'b0, 1'b0);

        // Random frames: widths, parity modes, bad parity/stop bits, gaps, glitches, mid-frame config changes
        for (int s = 0; s < 15; s++) begin
            n_ticks = 0;
            add_level(1'b1, $urandom_range(2, 30), 4'd0, 2'b00);
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                w  = 4'($urandom_range(0, 15));
                p  = 2'($urandom_range(0, 3));
                d  = 16'($urandom);
                nb = (w == 4'd0) ? 16 : int'(w);
                mask = (nb == 16) ? 16'hFFFF : ((16'd1 << nb) - 16'd1);
                pb = (^(d & mask)) ^ p[0];
                if ($urandom_range(0, 3) == 0) pb = ~pb;
                sb = ($urandom_range(0, 4) != 0);
                fs = n_ticks;
                add_frame(d, w, p, pb, sb);
                if ($urandom_range(0, 2) == 0) begin
                    cut = fs + $urandom_range(4, n_ticks - fs - 1);
                    nw = 4'($urandom_range(0, 15));
                    np = 2'($urandom_range(0, 3));
                    for (int t = cut; t < n_ticks; t++) begin
                        W_a[t] = nw; P_a[t] = np;
                    end
                end
                g = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 50);
                if (g >= 12 && $urandom_range(0, 1) == 1) begin
                    add_level(1'b1, 4, w, p);
                    add_level(1'b0, $urandom_range(1, 6), w, p);
                end
                add_level(1'b1, g, w, p);
            end
            add_level(1'b1, 40, 4'd0, 2'b00);
            run_segment();
            check("random frame count", dq_bits.size(), mq_bits.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
